dokmean_mul_arb: RTL and testbench
==================================

# dokmean_mul_arb

Round-robin arbiter and sequencer that shares one pipelined 7u×11s multiplier among N_REQ requesters in the k-means distance/update datapath. Each requester issues one operand pair with a valid/ready handshake and gets its result back on its own response port. The block tracks one outstanding operation per requester and holds results until the requester accepts them. It sits between the per-cluster accumulation lanes and the single DSP48 multiply resource.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- A_WIDTH, 7, unsigned operand width
- B_WIDTH, 11, signed operand width
- P_WIDTH, 11, signed result width
- NUM_STAGE, 2, multiplier pipeline registers (≥1)

Ports:
- ap_clk  in  1  clock; all logic on rising edge
- ap_rst  in  1  reset, asynchronous and active-high
- req_valid  in  N_REQ  per-requester operand valid
- req_ready  out  N_REQ  per-requester accept (one-hot or zero)
- req_a  in  N_REQ*A_WIDTH  unsigned operand, slice i for requester i
- req_b  in  N_REQ*B_WIDTH  signed operand, slice i
- rsp_valid  out  N_REQ  result valid per requester
- rsp_ready  in  N_REQ  result accept per requester
- rsp_p  out  N_REQ*P_WIDTH  signed result, slice i
- busy  out  1  any operation in flight or unaccepted

## Operation
- Eligible(i) = req_valid[i] & !outstanding[i].
- Grant: the first eligible index found scanning from (last+1) mod N_REQ upward with wrap. req_ready = one-hot grant, combinational from req_valid and state. req_valid must not depend on req_ready.
- Accept at an edge when req_valid[i] & req_ready[i]: set outstanding[i], set last = i, issue ({1'b0,a} × signed b) with tag i into the pipe.
- Full product is 18-bit signed. The result is the low P_WIDTH bits (wrap), or saturated (see Configuration).
- Pipe exit: write the result into slot i and set rsp_valid[i]. No collision is possible, because at most one op per requester is in flight.
- Response handshake rsp_valid[i] & rsp_ready[i]: clear rsp_valid[i] and outstanding[i].
- A requester cannot be re-granted in the same cycle its response is accepted. It becomes eligible the following cycle.
- rsp_p[i] holds its value until the next result for requester i.
- busy = |outstanding.
- Valid dropped before accept: nothing is issued and the pointer is unchanged. Valid dropped after accept: no effect on the op.

## Timing
- Reset values: req_ready=0 (no state-driven grant while in reset), rsp_valid=0, rsp_p=0, busy=0, outstanding=0, last=N_REQ-1 (requester 0 has first priority).
- Reset mid-operation: all in-flight ops are discarded and no response is emitted.
- Latency: accept at edge t → rsp_valid[i] high after edge t+NUM_STAGE, i.e. visible in cycle t+NUM_STAGE+1.
- Throughput: one accept per cycle whenever an eligible requester exists.
- With N_REQ > NUM_STAGE+1 and rsp_ready held high, sustained rate is 1 op/cycle. Otherwise a requester stalls until its response is accepted.

## Configuration
- DOKMEAN_MUL_ARB_SAT_EN defined: the result saturates to [-2^(P_WIDTH-1), 2^(P_WIDTH-1)-1].
- Undefined: the result is the two's-complement truncation of the 18-bit product.
- No other behavioural difference.

## Structure
- Package dokmean_mul_arb_pkg:
  - A_WIDTH/B_WIDTH/P_WIDTH defaults
  - FULL_WIDTH = A_WIDTH+B_WIDTH
  - tag width = clog2(N_REQ)
  - saturate/truncate function
- Sub-module dokmean_mul_arb_pipe: NUM_STAGE-deep pipelined multiplier carrying valid and tag alongside the product.
- The arbiter, outstanding flags and result slots live in the top.

## Test plan
- Single op: req0 a=100, b=-5 → rsp_valid[0] in cycle t+3 (NUM_STAGE=2), rsp_p[0]=-500, busy high from t+1 until the response handshake.
- Overflow: a=127, b=1023 → 897 without macro, 1023 with DOKMEAN_MUL_ARB_SAT_EN. a=127, b=-20 → -492 without, -1024 with.
- Round robin: all four req_valid high, rsp_ready all high → grants 0,1,2,3,0,1… one per cycle, no gaps after fill.
- Backpressure: rsp_ready[2]=0 for 10 cycles → rsp_valid[2] and rsp_p[2] hold, req_ready[2] stays 0. Other requesters keep being served. Release → req2 re-granted the cycle after its handshake.
- Reset mid-flight: assert ap_rst 1 cycle after two accepts → all rsp_valid stay 0, busy=0. First grant after reset goes to req0.
- Single requester: only req3 valid → req_ready[3] pulses once per (NUM_STAGE+2) cycles, and the pointer leaves the others' priority unchanged.

Source files
------------

// File: rtl/dokmean_mul_arb_pkg.sv
// Shared widths and result-fitting helper for the dokmean_mul_arb multiplier arbiter.
// Honours DOKMEAN_MUL_ARB_SAT_EN: saturate instead of wrapping the product into P_WIDTH bits.
package dokmean_mul_arb_pkg;

   localparam int DEF_A_WIDTH = 7;
   localparam int DEF_B_WIDTH = 11;
   localparam int DEF_P_WIDTH = 11;
   localparam int FULL_WIDTH  = DEF_A_WIDTH + DEF_B_WIDTH;

   function automatic int tag_width(input int n_req);
      return (n_req > 1) ? $clog2(n_req) : 1;
   endfunction

   // Fits a sign-extended product into p_width bits; the caller keeps the low p_width bits.
   function automatic logic signed [31:0] fit_result(input logic signed [31:0] full,
                                                     input int p_width);
`ifdef DOKMEAN_MUL_ARB_SAT_EN
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (p_width - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (p_width - 1));
      if (full > hi) return hi;
      if (full < lo) return lo;
      return full;
`else
      return (full <<< (32 - p_width)) >>> (32 - p_width);
`endif
   endfunction

endpackage

// File: rtl/dokmean_mul_arb_pipe.sv
// NUM_STAGE-deep pipelined {1'b0,a} x signed b multiplier carrying valid and tag alongside.
module dokmean_mul_arb_pipe
   import dokmean_mul_arb_pkg::*;
#(
   parameter int A_WIDTH   = DEF_A_WIDTH,
   parameter int B_WIDTH   = DEF_B_WIDTH,
   parameter int TAG_W     = 2,
   parameter int NUM_STAGE = 2
) (
   input  logic                              ap_clk,
   input  logic                              ap_rst,
   input  logic                              in_valid,
   input  logic [TAG_W-1:0]                  in_tag,
   input  logic [A_WIDTH-1:0]                in_a,
   input  logic [B_WIDTH-1:0]                in_b,
   output logic                              out_valid,
   output logic [TAG_W-1:0]                  out_tag,
   output logic signed [A_WIDTH+B_WIDTH-1:0] out_p
);
   localparam int PW = A_WIDTH + B_WIDTH;

   logic signed [PW-1:0] a_ext, b_ext, prod;
   logic [NUM_STAGE-1:0] valid_reg;
   logic [TAG_W-1:0]     tag_reg  [NUM_STAGE];
   logic signed [PW-1:0] prod_reg [NUM_STAGE];

   // The true product always fits PW bits, so a PW x PW multiply is exact.
   assign a_ext = {{B_WIDTH{1'b0}}, in_a};
   assign b_ext = {{A_WIDTH{in_b[B_WIDTH-1]}}, in_b};
   assign prod  = a_ext * b_ext;

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         valid_reg <= '0;
         for (int s = 0; s < NUM_STAGE; s++) begin
            tag_reg[s]  <= '0;
            prod_reg[s] <= '0;
         end
      end else begin
         valid_reg[0] <= in_valid;
         tag_reg[0]   <= in_tag;
         prod_reg[0]  <= prod;
         for (int s = 1; s < NUM_STAGE; s++) begin
            valid_reg[s] <= valid_reg[s-1];
            tag_reg[s]   <= tag_reg[s-1];
            prod_reg[s]  <= prod_reg[s-1];
         end
      end
   end

   assign out_valid = valid_reg[NUM_STAGE-1];
   assign out_tag   = tag_reg[NUM_STAGE-1];
   assign out_p     = prod_reg[NUM_STAGE-1];

endmodule

// File: rtl/dokmean_mul_arb.sv
// Round-robin arbiter sharing one pipelined multiplier among N_REQ requesters, one op in flight each.
// Define DOKMEAN_MUL_ARB_SAT_EN to saturate results instead of wrapping them.
module dokmean_mul_arb
   import dokmean_mul_arb_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int A_WIDTH   = DEF_A_WIDTH,
   parameter int B_WIDTH   = DEF_B_WIDTH,
   parameter int P_WIDTH   = DEF_P_WIDTH,
   parameter int NUM_STAGE = 2
) (
   input  logic                     ap_clk,
   input  logic                     ap_rst,
   input  logic [N_REQ-1:0]         req_valid,
   output logic [N_REQ-1:0]         req_ready,
   input  logic [N_REQ*A_WIDTH-1:0] req_a,
   input  logic [N_REQ*B_WIDTH-1:0] req_b,
   output logic [N_REQ-1:0]         rsp_valid,
   input  logic [N_REQ-1:0]         rsp_ready,
   output logic [N_REQ*P_WIDTH-1:0] rsp_p,
   output logic                     busy
);
   localparam int TAG_W  = tag_width(N_REQ);
   localparam int PROD_W = A_WIDTH + B_WIDTH;

   logic [N_REQ-1:0]          outstanding_reg, rsp_valid_reg;
   logic [N_REQ-1:0]          eligible, grant, accept_vec, rsp_fire;
   logic [TAG_W-1:0]          last_reg, grant_idx;
   logic                      found;
   logic [A_WIDTH-1:0]        a_arr    [N_REQ];
   logic [B_WIDTH-1:0]        b_arr    [N_REQ];
   logic [P_WIDTH-1:0]        slot_reg [N_REQ];
   logic                      pipe_valid;
   logic [TAG_W-1:0]          pipe_tag;
   logic signed [PROD_W-1:0]  pipe_p;
   logic signed [31:0]        fit_val;
   logic [P_WIDTH-1:0]        result;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign a_arr[gi] = req_a[gi*A_WIDTH +: A_WIDTH];
      assign b_arr[gi] = req_b[gi*B_WIDTH +: B_WIDTH];
      assign rsp_p[gi*P_WIDTH +: P_WIDTH] = slot_reg[gi];
   end

   // outstanding stays set through the response handshake cycle, which blocks same-cycle re-grant.
   assign eligible = req_valid & ~outstanding_reg;

   always_comb begin
      int idx;
      idx       = 0;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(last_reg) + k) % N_REQ;
         if (!found && eligible[idx]) begin
            found     = 1'b1;
            grant_idx = TAG_W'(idx);
         end
      end
      if (found && !ap_rst) grant[grant_idx] = 1'b1;
   end

   assign req_ready  = grant;
   assign accept_vec = req_valid & grant;
   assign rsp_fire   = rsp_valid_reg & rsp_ready;

   dokmean_mul_arb_pipe #(
      .A_WIDTH   (A_WIDTH),
      .B_WIDTH   (B_WIDTH),
      .TAG_W     (TAG_W),
      .NUM_STAGE (NUM_STAGE)
   ) u_pipe (
      .ap_clk    (ap_clk),
      .ap_rst    (ap_rst),
      .in_valid  (|accept_vec),
      .in_tag    (grant_idx),
      .in_a      (a_arr[grant_idx]),
      .in_b      (b_arr[grant_idx]),
      .out_valid (pipe_valid),
      .out_tag   (pipe_tag),
      .out_p     (pipe_p)
   );

   assign fit_val = fit_result(32'(pipe_p), P_WIDTH);
   assign result  = P_WIDTH'(fit_val);

   // A slot is never written while its response is pending, so exit and handshake cannot clash.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         outstanding_reg <= '0;
         rsp_valid_reg   <= '0;
         last_reg        <= TAG_W'(N_REQ - 1);
         for (int i = 0; i < N_REQ; i++) slot_reg[i] <= '0;
      end else begin
         outstanding_reg <= (outstanding_reg | accept_vec) & ~rsp_fire;
         if (|accept_vec) last_reg <= grant_idx;
         for (int i = 0; i < N_REQ; i++) begin
            if (pipe_valid && pipe_tag == TAG_W'(i)) begin
               rsp_valid_reg[i] <= 1'b1;
               slot_reg[i]      <= result;
            end else if (rsp_fire[i]) begin
               rsp_valid_reg[i] <= 1'b0;
            end
         end
      end
   end

   assign rsp_valid = rsp_valid_reg;
   assign busy      = |outstanding_reg;

endmodule

// File: tb/tb_dokmean_mul_arb.sv
// Randomised and directed bench for dokmean_mul_arb against a cycle-level behavioural model.
module tb_dokmean_mul_arb;
   localparam int N  = 4;
   localparam int AW = 7;
   localparam int BW = 11;
   localparam int PW = 11;
   localparam int NS = 2;

   logic            ap_clk = 1'b0;
   logic            ap_rst = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [N*AW-1:0] req_a = '0;
   logic [N*BW-1:0] req_b = '0;
   logic [N-1:0]    rsp_valid;
   logic [N-1:0]    rsp_ready = '0;
   logic [N*PW-1:0] rsp_p;
   logic            busy;

   dokmean_mul_arb dut (
      .ap_clk    (ap_clk),
      .ap_rst    (ap_rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_p     (rsp_p),
      .busy      (busy)
   );

   always #5 ap_clk = ~ap_clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic int model_result(input int a, input int b);
      int full;
      int r;
      full = a * b;
`ifdef DOKMEAN_MUL_ARB_SAT_EN
      r = (full > 1023) ? 1023 : ((full < -1024) ? -1024 : full);
`else
      r = full & 2047;
      if (r >= 1024) r = r - 2048;
`endif
      return r;
   endfunction

   function automatic int dut_rsp(input int i);
      return int'($signed(rsp_p[i*PW +: PW]));
   endfunction

   // ---------------- behavioural model ----------------
   int  cyc = 0;
   bit  m_out  [N];
   bit  m_pend [N];
   int  m_due  [N];
   int  m_pval [N];
   bit  m_rv   [N];
   int  m_rp   [N];
   int  m_last = N - 1;
   int  g_exp;
   int  exp_ready;
   int  exp_rv;
   int  exp_busy;

   always @(negedge ap_clk) begin
      if (ap_rst) begin
         for (int i = 0; i < N; i++) begin
            m_out[i] = 0; m_pend[i] = 0; m_rv[i] = 0; m_rp[i] = 0;
         end
         m_last = N - 1;
         chk("rst_req_ready", int'(req_ready), 0);
         chk("rst_rsp_valid", int'(rsp_valid), 0);
         chk("rst_busy", int'(busy), 0);
      end else begin
         for (int i = 0; i < N; i++) begin
            if (m_pend[i] && m_due[i] == cyc) begin
               m_rv[i] = 1; m_rp[i] = m_pval[i]; m_pend[i] = 0;
            end
         end
         g_exp = -1;
         for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_last + k) % N;
            if (g_exp < 0 && req_valid[j] && !m_out[j]) g_exp = j;
         end
         exp_ready = (g_exp >= 0) ? (1 << g_exp) : 0;
         exp_rv = 0;
         exp_busy = 0;
         for (int i = 0; i < N; i++) begin
            if (m_rv[i]) exp_rv = exp_rv | (1 << i);
            if (m_out[i]) exp_busy = 1;
         end
         chk("req_ready", int'(req_ready), exp_ready);
         chk("rsp_valid", int'(rsp_valid), exp_rv);
         chk("busy", int'(busy), exp_busy);
         for (int i = 0; i < N; i++) chk($sformatf("rsp_p%0d", i), dut_rsp(i), m_rp[i]);
         for (int i = 0; i < N; i++) begin
            if (g_exp == i && req_valid[i]) begin
               m_out[i]  = 1;
               m_last    = i;
               m_pend[i] = 1;
               m_due[i]  = cyc + NS + 1;
               m_pval[i] = model_result(int'(req_a[i*AW +: AW]), int'($signed(req_b[i*BW +: BW])));
            end
            if (m_rv[i] && rsp_ready[i]) begin
               m_rv[i]  = 0;
               m_out[i] = 0;
            end
         end
      end
      cyc++;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic set_op(input int i, input int a, input int b);
      req_a[i*AW +: AW] = AW'(a);
      req_b[i*BW +: BW] = BW'(b);
   endtask

   task automatic rand_ops();
      for (int i = 0; i < N; i++) set_op(i, int'($urandom_range(0, 127)), int'($urandom_range(0, 2047)) - 1024);
   endtask

   initial begin
      int lat;
      int cnt;
      int other;
      int seen;

      repeat (3) tick();
      ap_rst = 1'b0;

      chk("pin_model_neg500", model_result(100, -5), -500);
`ifdef DOKMEAN_MUL_ARB_SAT_EN
      chk("pin_model_ovf_pos", model_result(127, 1023), 1023);
      chk("pin_model_ovf_neg", model_result(127, -20), -1024);
`else
      chk("pin_model_ovf_pos", model_result(127, 1023), 897);
      chk("pin_model_ovf_neg", model_result(127, -20), -492);
`endif

      // single op on requester 0
      set_op(0, 100, -5);
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      lat = 1;
      while (!rsp_valid[0] && lat < 20) begin
         tick();
         lat++;
      end
      chk("single_latency", lat, NS + 1);
      chk("single_p", dut_rsp(0), -500);
      chk("single_busy", int'(busy), 1);
      repeat (2) tick();
      chk("single_hold_p", dut_rsp(0), -500);
      rsp_ready = 4'b0001;
      tick();
      rsp_ready = '0;
      chk("single_busy_clr", int'(busy), 0);

      // overflow on requesters 1 and 2
      set_op(1, 127, 1023);
      set_op(2, 127, -20);
      req_valid = 4'b0110;
      repeat (2) tick();
      req_valid = '0;
      repeat (4) tick();
      chk("ovf_valid", int'(rsp_valid), 6);
`ifdef DOKMEAN_MUL_ARB_SAT_EN
      chk("ovf_pos", dut_rsp(1), 1023);
      chk("ovf_neg", dut_rsp(2), -1024);
`else
      chk("ovf_pos", dut_rsp(1), 897);
      chk("ovf_neg", dut_rsp(2), -492);
`endif
      rsp_ready = 4'b1111;
      tick();
      rsp_ready = '0;

      // reset one cycle after two accepts
      rand_ops();
      req_valid = 4'b1111;
      repeat (2) tick();
      ap_rst = 1'b1;
      req_valid = '0;
      tick();
      ap_rst = 1'b0;
      repeat (6) begin
         tick();
         chk("midrst_rsp_valid", int'(rsp_valid), 0);
         chk("midrst_busy", int'(busy), 0);
      end

      // round robin from reset, all responses accepted immediately
      rsp_ready = 4'b1111;
      rand_ops();
      req_valid = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         @(negedge ap_clk);
         chk("rr_grant", int'(req_ready), 1 << (c % 4));
         tick();
         rand_ops();
      end

      // backpressure on requester 2
      rsp_ready = 4'b1011;
      other = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge ap_clk);
         if (c >= 5) chk("bp_ready2", int'(req_ready[2]), 0);
         if ((req_ready & 4'b1011) != 0) other++;
         tick();
         rand_ops();
      end
      chk("bp_rsp2_held", int'(rsp_valid[2]), 1);
      chk("bp_others_served", int'(other >= 6), 1);
      rsp_ready = 4'b1111;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge ap_clk);
         if (req_ready[2]) seen = 1;
         tick();
      end
      chk("bp_regrant", seen, 1);

      // single requester
      req_valid = '0;
      repeat (8) tick();
      req_valid = 4'b1000;
      cnt = 0;
      for (int c = 0; c < 24; c++) begin
         @(negedge ap_clk);
         if (req_ready[3]) cnt++;
         tick();
      end
      chk("single_req_pulses", cnt, 6);
      req_valid = '0;
      repeat (8) tick();

      // random traffic with occasional reset
      for (int c = 0; c < 1500; c++) begin
         req_valid = N'($urandom);
         rsp_ready = ($urandom_range(0, 3) == 0) ? N'($urandom) : 4'b1111;
         rand_ops();
         ap_rst = ($urandom_range(0, 299) == 0);
         tick();
      end
      ap_rst = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
